// File: rtl/byte_strip_sched.sv
// Stripe scheduler: spreads a byte stream round-robin over 1/2/4 lanes, pads the
// last stripe of a frame and inserts IDLE stripes after a quiet gap.
module byte_strip_sched #(
   parameter logic [7:0]  PAD_CHAR  = 8'hF7,
   parameter logic [7:0]  IDLE_CHAR = 8'hBC,
   parameter int unsigned IDLE_GAP  = 16
) (
   input  logic       CLK,
   input  logic       RESET_L,
   input  logic [1:0] LANE_CFG,
   input  logic [7:0] IN_DATA,
   input  logic       IN_K,
   input  logic       IN_VALID,
   input  logic       IN_LAST,
   output logic       IN_READY,
   output logic [7:0] LANE0,
   output logic [7:0] LANE1,
   output logic [7:0] LANE2,
   output logic [7:0] LANE3,
   output logic       DK_0,
   output logic       DK_1,
   output logic       DK_2,
   output logic       DK_3,
   output logic       OUT_VALID,
   input  logic       OUT_READY,
   output logic       DBG_STATE
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; OUT_VALID holds the stripe stable until OUT_READY is seen.

   typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

   localparam logic [7:0] L_GAP = 8'(IDLE_GAP);

   state_t     r_state;
   logic [1:0] r_cfg;          // index of the last active lane (0, 1 or 3)
   logic [1:0] r_ptr;
   logic [7:0] r_idle_cnt;
   logic [7:0] r_stage_d [4];
   logic       r_stage_k [4];
   logic [7:0] r_lane_d  [4];
   logic       r_lane_k  [4];
   logic       r_out_valid;

   logic [1:0] w_nlast;
   logic       w_acc;
   logic       w_cmp;
   logic       w_idle_emit;
   logic [7:0] w_fill_d [4];
   logic       w_fill_k [4];

   function automatic logic [1:0] f_nlast(input logic [1:0] cfg);
      case (cfg)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Between frames the live LANE_CFG applies, so a frame's first byte uses it.
   assign w_nlast     = (r_state == S_IDLE) ? f_nlast(LANE_CFG) : r_cfg;
   assign IN_READY    = !r_out_valid || OUT_READY;
   assign w_acc       = IN_VALID && IN_READY;
   assign w_cmp       = w_acc && ((r_ptr == w_nlast) || IN_LAST);
   assign w_idle_emit = (r_state == S_IDLE) && !w_acc && (r_idle_cnt == L_GAP) &&
                        (!r_out_valid || OUT_READY);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_fill_d[i] = 8'h00;
         w_fill_k[i] = 1'b0;
         if (2'(i) <= w_nlast) begin
            if (w_idle_emit) begin
               w_fill_d[i] = IDLE_CHAR;
               w_fill_k[i] = 1'b1;
            end else if (2'(i) < r_ptr) begin
               w_fill_d[i] = r_stage_d[i];
               w_fill_k[i] = r_stage_k[i];
            end else if (2'(i) == r_ptr) begin
               w_fill_d[i] = IN_DATA;
               w_fill_k[i] = IN_K;
            end else begin
               w_fill_d[i] = PAD_CHAR;
               w_fill_k[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_state     <= S_IDLE;
         r_cfg       <= 2'd3;
         r_ptr       <= 2'd0;
         r_idle_cnt  <= 8'd0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_stage_d[i] <= 8'h00;
            r_stage_k[i] <= 1'b0;
            r_lane_d[i]  <= 8'h00;
            r_lane_k[i]  <= 1'b0;
         end
      end else begin
         if (r_state == S_IDLE) r_cfg <= w_nlast;

         if (w_acc) begin
            if (w_cmp) begin
               r_ptr <= 2'd0;
            end else begin
               r_stage_d[r_ptr] <= IN_DATA;
               r_stage_k[r_ptr] <= IN_K;
               r_ptr            <= r_ptr + 2'd1;
            end
         end

         if (w_cmp || w_idle_emit) begin
            r_out_valid <= 1'b1;
            for (int i = 0; i < 4; i++) begin
               r_lane_d[i] <= w_fill_d[i];
               r_lane_k[i] <= w_fill_k[i];
            end
         end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_acc || w_idle_emit) r_idle_cnt <= 8'd0;
               else if (r_idle_cnt != L_GAP) r_idle_cnt <= r_idle_cnt + 8'd1;
               if (w_acc && !IN_LAST) r_state <= S_FRAME;
            end
            default: begin
               r_idle_cnt <= 8'd0;
               if (w_acc && IN_LAST) r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign LANE0     = r_lane_d[0];
   assign LANE1     = r_lane_d[1];
   assign LANE2     = r_lane_d[2];
   assign LANE3     = r_lane_d[3];
   assign DK_0      = r_lane_k[0];
   assign DK_1      = r_lane_k[1];
   assign DK_2      = r_lane_k[2];
   assign DK_3      = r_lane_k[3];
   assign OUT_VALID = r_out_valid;
   assign DBG_STATE = (r_state == S_FRAME);

endmodule

// File: doc/byte_strip_sched.md
# byte_strip_sched

Stripe scheduler that feeds the four-lane byte datapath. It accepts a single byte stream with a valid/ready handshake and distributes consecutive bytes round-robin across 1, 2 or 4 active lanes. Each complete stripe is presented as one registered lane word, and partial stripes at frame end are closed with PAD symbols. During idle gaps it inserts IDLE stripes so the lanes keep carrying control symbols for the unstriping side.

## Interface
- PAD_CHAR, 8'hF7, control byte that fills unused lanes of the last stripe of a frame (sent with DK=1).
- IDLE_CHAR, 8'hBC, control byte sent on every active lane of an idle stripe (DK=1).
- IDLE_GAP, 16, number of consecutive idle cycles between frames before an idle stripe is emitted; legal range 1..255.
- CLK  in  1  single clock; all state updates on rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- LANE_CFG  in  2  active lanes: 00=x1, 01=x2, 10=x4, 11=x4. Sampled only at frame start.
- IN_DATA  in  8  input byte.
- IN_K  in  1  IN_DATA is a control symbol.
- IN_VALID  in  1  input byte valid.
- IN_LAST  in  1  byte is last of frame.
- IN_READY  out  1  scheduler can accept a byte this cycle.
- LANE0..LANE3  out  8 each  stripe bytes; lane n carries byte n of the stripe.
- DK_0..DK_3  out  1 each  control flag per lane.
- OUT_VALID  out  1  stripe on LANE*/DK_* is valid.
- OUT_READY  in  1  downstream accepts the stripe.

## Operation
- Active width N = 1/2/4, latched into register CFG_Q.
  - Latching happens when the FSM is in IDLE and a byte is accepted, or at any idle cycle.
  - LANE_CFG changes while in FRAME are ignored until the frame ends.
- Byte accept: IN_VALID && IN_READY.
  - Byte goes into staging slot PTR, with its K flag.
  - PTR increments modulo N.
- Stripe completion, in the same accept cycle, occurs when either:
  - PTR==N-1, or
  - IN_LAST=1.
- On completion:
  - Slots PTR+1..N-1 are filled with PAD_CHAR, DK=1.
  - The staging slots are copied into the output registers and OUT_VALID is set.
  - PTR returns to 0.
- Lanes at index N and above are always driven 8'h00, DK=0.
- FSM:
  - IDLE to FRAME: on an accepted byte without IN_LAST.
  - FRAME to IDLE: on an accepted byte with IN_LAST.
  - A byte with IN_LAST accepted in IDLE completes the stripe and stays in IDLE.
- Idle insertion, in IDLE only:
  - Counter IDLE_CNT increments each cycle with no accepted byte, saturating at IDLE_GAP.
  - When IDLE_CNT==IDLE_GAP and the output slot is free (OUT_VALID=0 or OUT_READY=1), the block emits a stripe of IDLE_CHAR on lanes 0..N-1 with DK=1 and clears IDLE_CNT.
  - In FRAME, IDLE_CNT is held at 0.
  - If a byte is accepted in the same cycle IDLE_CNT reaches IDLE_GAP, the data takes priority: no idle stripe is emitted and IDLE_CNT is cleared.
- Backpressure:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - The output stripe holds stable while OUT_VALID && !OUT_READY.
  - A completing byte cannot be accepted while the output is stalled. Non-completing bytes are also blocked, because IN_READY is the same signal.
- OUT_VALID clears after a handshake unless a new stripe completes in the same cycle.

## Timing
- Reset (RESET_L=0, asynchronous):
  - LANE0..3=8'h00, DK_0..3=0, OUT_VALID=0.
  - PTR=0, IDLE_CNT=0, FSM=IDLE, CFG_Q=x4.
  - The staging contents and any partial stripe are discarded.
- IN_READY during reset: 1. It is a combinational function of OUT_VALID=0.
- Latency: a byte completing a stripe at rising edge k makes OUT_VALID=1 with that stripe visible from edge k to edge k+1.
- Throughput (no stall):
  - x4: one stripe per 4 accepted bytes.
  - x2: one stripe per 2 accepted bytes.
  - x1: one stripe per accepted byte.
- A back-to-back stripe with OUT_READY=1 keeps OUT_VALID high continuously, with new lane values each completion.
- First idle stripe appears IDLE_GAP+1 edges after the last accept, provided the output slot is free.
- Reset released mid-stall: OUT_VALID returns to 0 and the pending stripe is lost. This is required behaviour.

## Test plan
- x4 frame, OUT_READY=1, bytes 11,22,33,44,55 with LAST on 55 -> stripe {11,22,33,44}, DK all 0, then stripe {55,F7,F7,F7} with DK=0,1,1,1. Each stripe has OUT_VALID for 1 cycle, and the FSM returns to IDLE.
- x2, bytes A1(K=1),B2,C3(LAST) -> {A1,B2} with DK_0=1, then {C3,F7} with DK=0,1; lanes 2,3 = 00 with DK=0.
- Stall: x1, OUT_READY=0 after the first stripe -> IN_READY=0, LANE0 holds its value. Raising OUT_READY for 1 cycle accepts the next byte the same cycle, and there is no loss or duplication across 8 bytes.
- Idle: IDLE_GAP=4, x4, no input -> stripe {BC,BC,BC,BC} with DK=1111 every 5 cycles. A byte arriving on the cycle IDLE_CNT hits 4 suppresses the idle stripe.
- Config: LANE_CFG switched from x4 to x1 after the 2nd byte of a 6-byte frame -> the frame completes as x4 ({b0..b3},{b4,b5,F7,F7}). The next frame is striped x1.
- Reset mid-frame after 3 of 4 bytes -> all outputs 0 and OUT_VALID=0. The next 4 bytes form a fresh stripe starting at lane 0.
